// File: rtl/top_level_pkg.sv
// ============================================================================
// top_level_pkg: shared constants, state encoding, tap table and LFSR step
// Rev 1.0
// ============================================================================
`default_nettype none

package top_level_pkg;

    localparam int MSG_BASE = 64;
    localparam int MSG_LEN  = 64;
    localparam int CHK_LEN  = 9;
    localparam int NUM_PTRN = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        DECRYPT = 3'd2,
        PAD     = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Candidate feedback tap patterns, searched in index order
    function automatic logic [6:0] ptrn_tap(input logic [3:0] idx);
        case (idx)
            4'd0:    return 7'h60;
            4'd1:    return 7'h48;
            4'd2:    return 7'h78;
            4'd3:    return 7'h72;
            4'd4:    return 7'h6A;
            4'd5:    return 7'h69;
            4'd6:    return 7'h5C;
            4'd7:    return 7'h7E;
            4'd8:    return 7'h7B;
            default: return 7'h60;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] taps);
        return {s[5:0], ^(s & taps)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/top_level_data_mem.sv
// ============================================================================
// data_mem: 256x8 memory, combinational read, synchronous write, no reset
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] core [0:255];

    always_ff @(posedge clk) begin
        if (we_i) begin
            core[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = core[raddr_i];

endmodule

`default_nettype wire

// File: rtl/top_level.sv
// ============================================================================
// top_level: LFSR message decryption engine (tap search, decrypt, de-pad)
// Rev 1.0
// ============================================================================
`default_nettype none

module top_level
    import top_level_pkg::*;
(
    input  logic clk,
    input  logic init,
    input  logic req,
    output logic ack
);

    state_t     state_q, state_d;
    logic       armed_q, armed_d;
    logic [3:0] k_q,     k_d;
    logic [3:0] j_q,     j_d;
    logic [6:0] cur_q,   cur_d;
    logic [6:0] base_q,  base_d;
    logic [3:0] ptrn_q,  ptrn_d;
    logic [6:0] lfsr_q,  lfsr_d;
    logic [5:0] i_q,     i_d;
    logic [6:0] wptr_q,  wptr_d;
    logic       skip_q,  skip_d;

    logic [7:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic [6:0] w_rd7;
    logic       w_unused_msb;
    logic       w_we;
    logic [7:0] w_wr_addr;
    logic [7:0] w_wr_data;
    logic [6:0] w_cur;
    logic       w_match;
    logic [6:0] w_plain;
    logic       w_keep;

    data_mem DM (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (w_wr_addr),
        .wdata_i (w_wr_data),
        .raddr_i (w_rd_addr),
        .rdata_o (w_rd_data)
    );

    assign {w_unused_msb, w_rd7} = w_rd_data;

    // First step of every candidate starts from the latched preamble byte 0
    assign w_cur   = (j_q == 4'd1) ? base_q : cur_q;
    assign w_match = (lfsr_next(w_cur, ptrn_tap(k_q)) == w_rd7);
    assign w_plain = w_rd7 ^ lfsr_q;
    assign w_keep  = !(skip_q && (w_plain == 7'd0));

    always_ff @(posedge clk) begin
        if (!init) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            k_q     <= 4'd0;
            j_q     <= 4'd0;
            cur_q   <= 7'd0;
            base_q  <= 7'd0;
            ptrn_q  <= 4'd0;
            lfsr_q  <= 7'd0;
            i_q     <= 6'd0;
            wptr_q  <= 7'd0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            k_q     <= k_d;
            j_q     <= j_d;
            cur_q   <= cur_d;
            base_q  <= base_d;
            ptrn_q  <= ptrn_d;
            lfsr_q  <= lfsr_d;
            i_q     <= i_d;
            wptr_q  <= wptr_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        k_d     = k_q;
        j_d     = j_q;
        cur_d   = cur_q;
        base_d  = base_q;
        ptrn_d  = ptrn_q;
        lfsr_d  = lfsr_q;
        i_d     = i_q;
        wptr_d  = wptr_q;
        skip_d  = skip_q;
        case (state_q)
            IDLE: begin
                base_d = w_rd7;
                if (req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    k_d     = 4'd0;
                    j_d     = 4'd1;
                    i_d     = 6'd0;
                    wptr_d  = 7'd0;
                    skip_d  = 1'b1;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (w_match) begin
                    if (j_q == 4'(CHK_LEN)) begin
                        ptrn_d  = k_q;
                        lfsr_d  = base_q;
                        state_d = DECRYPT;
                    end else begin
                        cur_d = w_rd7;
                        j_d   = j_q + 4'd1;
                    end
                end else if (k_q == 4'(NUM_PTRN - 1)) begin
                    ptrn_d  = 4'd0;
                    lfsr_d  = base_q;
                    state_d = DECRYPT;
                end else begin
                    k_d = k_q + 4'd1;
                    j_d = 4'd1;
                end
            end
            DECRYPT: begin
                lfsr_d = lfsr_next(lfsr_q, ptrn_tap(ptrn_q));
                i_d    = i_q + 6'd1;
                if (w_keep) begin
                    skip_d = 1'b0;
                    wptr_d = wptr_q + 7'd1;
                end
                if (i_q == 6'(MSG_LEN - 1)) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (wptr_q == 7'(MSG_LEN)) begin
                    state_d = DONE;
                end else begin
                    wptr_d = wptr_q + 7'd1;
                    if (wptr_q == 7'(MSG_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (req) begin
                    armed_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack       = 1'b0;
        w_rd_addr = 8'(MSG_BASE);
        w_we      = 1'b0;
        w_wr_addr = {1'b0, wptr_q};
        w_wr_data = 8'h00;
        case (state_q)
            SEARCH:  w_rd_addr = 8'(MSG_BASE) + {4'b0000, j_q};
            DECRYPT: begin
                w_rd_addr = 8'(MSG_BASE) + {2'b00, i_q};
                w_we      = w_keep;
                w_wr_data = {1'b0, w_plain};
            end
            PAD:     w_we = (wptr_q != 7'(MSG_LEN));
            DONE:    ack  = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_top_level.sv
// ============================================================================
// tb_top_level: directed self-checking bench for the LFSR decryption engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_top_level;
    import top_level_pkg::*;

    logic clk  = 1'b0;
    logic init = 1'b0;
    logic req  = 1'b0;
    logic ack;

    int errors = 0;
    int checks = 0;
    int cycles = 0;
    logic [7:0] exp_out [64];
    logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    top_level dut (
        .clk  (clk),
        .init (init),
        .req  (req),
        .ack  (ack)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Encrypts preamble+message+space fill into 64..127 and builds the expected output
    task automatic load_msg(input string msg, input int pre, input logic [6:0] tap,
                            input logic [6:0] seed, input bit hi7);
        logic [6:0] st;
        logic [6:0] pt;
        logic [7:0] ch;
        logic       b7;
        int         n;
        bit         seen;
        st   = seed;
        n    = 0;
        seen = 1'b0;
        for (int a = 0; a < 64; a++) begin
            dut.DM.core[a] = 8'hA5;
            exp_out[a]     = 8'h00;
        end
        for (int i = 0; i < 64; i++) begin
            if (i >= pre && (i - pre) < msg.len()) ch = msg[i - pre];
            else ch = 8'h20;
            pt = 7'(ch - 8'h20);
            b7 = hi7 ? 1'($urandom_range(0, 1)) : 1'b0;
            dut.DM.core[64 + i] = {b7, pt ^ st};
            if (pt != 7'd0) seen = 1'b1;
            if (seen) begin
                exp_out[n] = {1'b0, pt};
                n++;
            end
            st = {st[5:0], ^(st & tap)};
        end
    endtask

    task automatic wait_ack(input string tag);
        cycles = 0;
        while (ack !== 1'b1 && cycles < 250) begin
            tick(1);
            cycles++;
        end
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk({tag, "_latency_le_211"}, 32'(cycles <= 211), 32'd1);
    endtask

    task automatic run(input string tag);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        wait_ack(tag);
    endtask

    task automatic check_out(input string tag);
        for (int a = 0; a < 64; a++) begin
            chk($sformatf("%s_core%0d", tag, a), 32'(dut.DM.core[a]), 32'(exp_out[a]));
        end
    endtask

    initial begin
        // Reset
        init = 1'b0;
        req  = 1'b0;
        tick(2);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        init = 1'b1;
        tick(5);
        chk("idle_unarmed_state", 32'(dut.state_q), 32'(IDLE));

        // Pattern 7E, seed 36, 10-space preamble plus leading spaces in the message
        load_msg("  0123456789abcdefghijklmnopqrstuvwxyz. ", 10, 7'h7E, 7'h36, 1'b0);
        run("msg1");
        chk("msg1_core0", 32'(dut.DM.core[0]), 32'h10);
        chk("msg1_core1", 32'(dut.DM.core[1]), 32'h11);
        check_out("msg1");
        tick(3);
        chk("done_ack_held", 32'(ack), 32'd1);

        // Pattern 60, seed 01, 15-space preamble; restart straight from DONE
        load_msg("Mr. Watson, come here. I want to see you.", 15, 7'h60, 7'h01, 1'b0);
        run("msg2");
        chk("msg2_core0", 32'(dut.DM.core[0]), 32'h2D);
        chk("msg2_core1", 32'(dut.DM.core[1]), 32'h52);
        check_out("msg2");

        // All spaces: nothing kept by decrypt, pad fills the whole output
        load_msg("", 10, 7'h7B, 7'h7F, 1'b0);
        run("allspace");
        check_out("allspace");

        // Every candidate pattern from seed 01
        for (int t = 0; t < 9; t++) begin
            load_msg("Hi!", 10, taps[t], 7'h01, 1'b0);
            run($sformatf("tap%0d", t));
            chk($sformatf("tap%0d_core0", t), 32'(dut.DM.core[0]), 32'h28);
            check_out($sformatf("tap%0d", t));
        end

        // Reset during DECRYPT aborts, then a fresh run completes
        load_msg("Mr. Watson, come here. I want to see you.", 15, 7'h60, 7'h01, 1'b0);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        tick(30);
        chk("mid_state_decrypt", 32'(dut.state_q), 32'(DECRYPT));
        init = 1'b0;
        tick(1);
        init = 1'b1;
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        tick(3);
        chk("abort_stays_idle", 32'(dut.state_q), 32'(IDLE));
        run("rerun");
        check_out("rerun");

        // req held high parks the engine; bit 7 of input bytes is ignored
        init = 1'b0;
        tick(1);
        init = 1'b1;
        req  = 1'b1;
        tick(20);
        chk("parked_ack", 32'(ack), 32'd0);
        chk("parked_state", 32'(dut.state_q), 32'(IDLE));
        load_msg("Bit7 noise!", 12, 7'h69, 7'h2B, 1'b1);
        tick(2);
        chk("parked_state2", 32'(dut.state_q), 32'(IDLE));
        req = 1'b0;
        wait_ack("bit7");
        chk("bit7_core0", 32'(dut.DM.core[0]), 32'h22);
        check_out("bit7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top_level.md
Name: top_level

Overview:
- Self-contained decryption engine for the LFSR-encrypted message (program 3a: decrypt and de-pad, no parity or error check).
- Holds a 256x8 data memory. The encrypted 64-byte block is preloaded at addresses 64..127.
- On start, it recovers the LFSR tap pattern and state from the known-space preamble, decrypts all 64 bytes, strips leading spaces, writes the plaintext to addresses 0..63, then raises ack.

Parameters:
- MSG_BASE, 64, address of encrypted byte 0.
- MSG_LEN, 64, number of encrypted bytes.
- CHK_LEN, 9, preamble steps checked per tap-pattern candidate (preamble is always at least 10 bytes).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- init  input  1  reset, synchronous and active-low (init=0 at a rising edge resets).
- req  input  1  start request; level held high parks the engine; the run starts on the first clock where req=0 after a 1 was sampled in IDLE.
- ack  output  1  done flag; high only in DONE.

Behaviour:
- Memory:
  - Instance name DM; internal array core[0:255] of 8 bits.
  - Combinational read, one synchronous write port.
  - Never cleared by reset, so backdoor preloads survive.
- LFSR step: next(s) = {s[5:0], ^(s & ptrn)}, 7 bits wide.
- Candidate tap patterns, indices 0..8: 60,48,78,72,6A,69,5C,7E,7B (hex).
- Data handling:
  - Only bits [6:0] of each encrypted byte are used; bit 7 is ignored.
  - Plaintext is stored as a 7-bit value (ASCII minus 0x20) with bit 7 = 0.
- Reset (init=0): state goes to IDLE, ack=0, armed flag=0, and all counters, pattern index and LFSR register clear.
- A reset mid-run aborts immediately; memory already written stays as is.
- IDLE:
  - ack=0; armed is set when req=1 is sampled.
  - Move to SEARCH when armed and req=0.
- SEARCH (one comparison per cycle):
  - For candidate k=0..8: cur = core[MSG_BASE][6:0]; for j=1..CHK_LEN, compare next(cur) with core[MSG_BASE+j][6:0].
  - On mismatch: k++, restart at j=1.
  - If all CHK_LEN steps match: latch ptrn=k, reload lfsr=core[MSG_BASE][6:0], go to DECRYPT.
  - If no candidate matches: use k=0.
  - Worst case 81 cycles.
- DECRYPT (i=0..MSG_LEN-1, one byte per cycle):
  - p = core[MSG_BASE+i][6:0] ^ lfsr; then lfsr = next(lfsr).
  - skip flag starts at 1. While skip=1 and p==0, nothing is written.
  - Otherwise clear skip, write core[wptr] = {1'b0,p}, then wptr++.
  - Zero bytes after the first nonzero byte are written normally (embedded and trailing spaces are kept).
- PAD: write 0x00 to core[wptr..MSG_LEN-1], one per cycle. If wptr reaches 64, go straight to DONE.
- DONE:
  - ack=1, held until reset.
  - If req=1 is sampled, return to IDLE with armed=1 (ack drops the next cycle).
- req changes during SEARCH, DECRYPT or PAD are ignored.
- Latency from start to ack is at most 81+64+64+2 cycles (211 cycles).
- Boundary case, all bytes decrypt to 0: wptr stays 0 and core[0..63] is all 0x00.
- Boundary case, no leading spaces after the preamble: output begins with the first non-preamble byte.

Decomposition:
- Package top_level_pkg holds:
  - the state enum (IDLE, SEARCH, DECRYPT, PAD, DONE);
  - the 9-entry tap table;
  - the MSG_BASE, MSG_LEN and CHK_LEN constants;
  - the lfsr_next function.
- Sub-module data_mem (256x8, async read, sync write), instantiated as DM with array core.
- The controller FSM stays in top_level.

Test Plan:
- Pattern 7E, init 36, pre_length 10, msg "  0123456789abcdefghijklmnopqrstuvwxyz. " -> ack within 211 cycles; core[0]=0x10 ('0'), core[1]=0x11; all 52 positions match plaintext minus 0x20.
- Pattern 60, init 01, pre 15, msg "Mr. Watson, come here. I want to see you." -> core[0]=0x2D ('M'), core[1]=0x52 ('r'); remaining positions match plaintext minus 0x20, zero-filled to 63.
- All-space message, pattern 7B, init 7F -> core[0..63]=0x00, ack=1.
- Each of the 9 patterns with init 01 -> correct pattern chosen, core[0] matches first non-space character.
- Reset mid-DECRYPT (init=0 for one cycle) -> ack=0, state IDLE; after a req 1-then-0 sequence the run completes correctly.
- req held at 1 after reset -> no progress and ack=0; req to 0 starts the run; bit 7 set in the input bytes does not change the output.
